planes_cpu_master: RTL and testbench

- Initiator side of the tile-plane CPU port: turns a single-word request/acknowledge transaction into a 68000-style VRAM/ROM-readback bus cycle.
- Drives the chip select, data strobe, direction and address/data lines that the tile-plane block consumes, then waits for its VDTAC acknowledge.
- Returns read data and reports timeouts.
- Used by the sim CPU model and by the boot-time VRAM loader.

---
 rtl/planes_cpu_master.sv | 182 ++++++++++++++++++
 tb/tb_planes_cpu_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/planes_cpu_master.sv
// Initiator for the tile-plane CPU port: turns a req/ack word transaction into a
// 68000-style VRAMCS/PDS bus cycle and waits for the plane chips' VDTAC.
module planes_cpu_master #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_main,
  input  logic        nRES,
  input  logic        req,
  input  logic        req_rnw,
  input  logic        req_rom,
  input  logic [16:0] req_addr,
  input  logic        req_upper,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        VRAMCS,
  output logic        PDS,
  output logic        NREAD,
  output logic        RMRD,
  output logic        m68k_addr_16,
  output logic [14:0] AB,
  output logic        nUDS,
  output logic [7:0]  DB_IN,
  input  logic        VDTAC,
  input  logic [7:0]  DB_OUT_k052109,
  input  logic [7:0]  DB_OUT_k051962
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] SETUP_L   = 16'(SETUP_CYC);
  localparam logic [15:0] HOLD_L    = 16'(HOLD_CYC);
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic        vdtac_meta_r, vdtac_sync_r;
  logic        err_pending_r;
  logic        load_s, strobe_on_s, strobe_off_s, latch_s, timeout_s, done_s;

  // Word-address bit 15 has no pin on this port.
  logic unused_addr_s;
  assign unused_addr_s = req_addr[15];

  // Next-state, counter and per-edge action decode.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    load_s       = 1'b0;
    strobe_on_s  = 1'b0;
    strobe_off_s = 1'b0;
    latch_s      = 1'b0;
    timeout_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          load_s      = 1'b1;
          state_nxt_s = ST_SETUP;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_L - 16'd1) begin
          strobe_on_s = 1'b1;
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_WAIT: begin
        // Acknowledge is tested first so it wins over a coincident timeout.
        if (!vdtac_sync_r) begin
          state_nxt_s = ST_LATCH;
          cnt_nxt_s   = 16'd0;
        end else if (cnt_r + 16'd1 == TIMEOUT_L) begin
          timeout_s    = 1'b1;
          strobe_off_s = 1'b1;
          state_nxt_s  = ST_RELEASE;
          cnt_nxt_s    = 16'd0;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_LATCH: begin
        latch_s      = 1'b1;
        strobe_off_s = 1'b1;
        state_nxt_s  = ST_RELEASE;
        cnt_nxt_s    = 16'd0;
      end
      ST_RELEASE: begin
        if ((vdtac_sync_r || err_pending_r) && (cnt_r >= HOLD_L)) begin
          done_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (cnt_r < HOLD_L) begin
          cnt_nxt_s = cnt_r + 16'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 16'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 16'd0;
      end
    endcase
  end

  // State, synchronizer and registered bus outputs.
  always_ff @(posedge clk_main or negedge nRES) begin
    if (!nRES) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      vdtac_meta_r  <= 1'b1;
      vdtac_sync_r  <= 1'b1;
      err_pending_r <= 1'b0;
      ack           <= 1'b0;
      err           <= 1'b0;
      rdata         <= 8'd0;
      busy          <= 1'b0;
      VRAMCS        <= 1'b1;
      PDS           <= 1'b0;
      NREAD         <= 1'b1;
      RMRD          <= 1'b0;
      m68k_addr_16  <= 1'b0;
      AB            <= 15'd0;
      nUDS          <= 1'b1;
      DB_IN         <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      vdtac_meta_r <= VDTAC;
      vdtac_sync_r <= vdtac_meta_r;
      ack          <= done_s;
      err          <= done_s ? err_pending_r : 1'b0;
      busy         <= (state_nxt_s != ST_IDLE);
      if (load_s) begin
        AB           <= req_addr[14:0];
        m68k_addr_16 <= req_addr[16];
        NREAD        <= req_rnw;
        RMRD         <= req_rom;
        nUDS         <= ~req_upper;
        if (!req_rnw) DB_IN <= req_wdata;
      end
      if (strobe_on_s) begin
        VRAMCS <= 1'b0;
        PDS    <= 1'b1;
      end
      if (strobe_off_s) begin
        VRAMCS <= 1'b1;
        PDS    <= 1'b0;
      end
      if (latch_s && NREAD) rdata <= RMRD ? DB_OUT_k051962 : DB_OUT_k052109;
      if (timeout_s) err_pending_r <= 1'b1;
      else if (state_r == ST_DONE) err_pending_r <= 1'b0;
      // Direction and lane return to idle one edge after the strobes.
      if (done_s) begin
        NREAD <= 1'b1;
        RMRD  <= 1'b0;
        nUDS  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_planes_cpu_master.sv
// Directed, table-driven bench for planes_cpu_master with a VDTAC responder model.
module tb_planes_cpu_master;

  logic        clk_main = 1'b0;
  logic        nRES = 1'b0;
  logic        req = 1'b0, req_rnw = 1'b0, req_rom = 1'b0, req_upper = 1'b0;
  logic [16:0] req_addr = 17'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        ack, err, busy, VRAMCS, PDS, NREAD, RMRD, m68k_addr_16, nUDS;
  logic [7:0]  rdata, DB_IN;
  logic [14:0] AB;
  logic        VDTAC = 1'b1;
  logic [7:0]  DB_OUT_k052109 = 8'd0, DB_OUT_k051962 = 8'd0;
  logic        resp_en = 1'b1;

  int tests = 0;
  int fails = 0;

  planes_cpu_master dut (
    .clk_main(clk_main), .nRES(nRES), .req(req), .req_rnw(req_rnw), .req_rom(req_rom),
    .req_addr(req_addr), .req_upper(req_upper), .req_wdata(req_wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .VRAMCS(VRAMCS), .PDS(PDS),
    .NREAD(NREAD), .RMRD(RMRD), .m68k_addr_16(m68k_addr_16), .AB(AB), .nUDS(nUDS),
    .DB_IN(DB_IN), .VDTAC(VDTAC), .DB_OUT_k052109(DB_OUT_k052109),
    .DB_OUT_k051962(DB_OUT_k051962)
  );

  always #5 clk_main = ~clk_main;

  // Responder: acknowledges while selected and strobed, releases when PDS drops.
  always @(negedge clk_main) begin
    if (!resp_en || !PDS) VDTAC = 1'b1;
    else if (!VRAMCS) VDTAC = 1'b0;
    else VDTAC = 1'b1;
  end

  typedef struct {
    logic        rnw;
    logic        rom;
    logic [16:0] addr;
    logic        upper;
    logic [7:0]  wdata;
    logic [7:0]  d52;
    logic [7:0]  d62;
    logic [14:0] e_ab;
    logic        e_a16;
    logic        e_nuds;
    logic [7:0]  e_dbin;
    logic [7:0]  e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic run_txn(input vec_t v, output int low_cnt);
    int n;
    int stable;
    req_rnw = v.rnw; req_rom = v.rom; req_addr = v.addr; req_upper = v.upper;
    req_wdata = v.wdata; DB_OUT_k052109 = v.d52; DB_OUT_k051962 = v.d62;
    req = 1'b1;
    stable = 0;
    n = 0;
    low_cnt = 0;
    while (n < 50) begin
      tick();
      n++;
      if (!VRAMCS) break;
      if (busy && AB == v.e_ab && m68k_addr_16 == v.e_a16 && nUDS == v.e_nuds &&
          NREAD == v.rnw && RMRD == v.rom && DB_IN == v.e_dbin) stable++;
      else stable = 0;
    end
    check("strobe_asserted", {31'd0, VRAMCS}, 32'd0);
    check("pds_with_cs", {31'd0, PDS}, 32'd1);
    check("setup_stable_cycles", stable, 2);
    check("addr_at_strobe", {m68k_addr_16, AB}, {v.e_a16, v.e_ab});
    check("ctrl_at_strobe", {NREAD, RMRD, nUDS}, {v.rnw, v.rom, v.e_nuds});
    low_cnt = 1;
    n = 0;
    while (!ack && n < 600) begin
      tick();
      n++;
      if (!VRAMCS) low_cnt++;
    end
    req = 1'b0;
    check("ack_seen", {31'd0, ack}, 32'd1);
    check("err", {31'd0, err}, {31'd0, v.e_err});
    check("rdata", rdata, v.e_rdata);
    check("done_ctrl", {VRAMCS, PDS, NREAD, RMRD, nUDS}, 5'b10101);
    check("done_hold", {DB_IN, m68k_addr_16, AB}, {v.e_dbin, v.e_a16, v.e_ab});
    tick();
    check("ack_pulse_end", {ack, busy}, 2'b00);
  endtask

  initial begin
    int lc;
    int acks;
    int run;
    int min_run;
    logic prev_vcs;
    logic seen_low;
    vec_t vt;

    //                rnw   rom   addr       up    wdata  d52    d62    ab          a16   nuds  dbin   rdata  err
    vecs[0] = '{1'b0, 1'b0, 17'h0C123, 1'b1, 8'h5A, 8'h00, 8'h00, 15'h4123, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 17'h10456, 1'b0, 8'hEE, 8'hA5, 8'h3C, 15'h0456, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 17'h10456, 1'b1, 8'hEE, 8'hA5, 8'h3C, 15'h0456, 1'b1, 1'b0, 8'h5A, 8'h3C, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 17'h17FFF, 1'b0, 8'h81, 8'h00, 8'h00, 15'h7FFF, 1'b1, 1'b1, 8'h81, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 17'h00000, 1'b1, 8'h00, 8'hFF, 8'h00, 15'h0000, 1'b0, 1'b0, 8'h81, 8'hFF, 1'b0};

    repeat (3) tick();
    check("reset_bus", {VRAMCS, PDS, NREAD, RMRD, nUDS, m68k_addr_16}, 6'b101010);
    check("reset_data", {AB, DB_IN, rdata}, 31'd0);
    check("reset_status", {ack, err, busy}, 3'b000);
    nRES = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], lc);

    // No responder: abort after TIMEOUT cycles of WAIT, rdata untouched.
    resp_en = 1'b0;
    vt = '{1'b1, 1'b1, 17'h08001, 1'b0, 8'h00, 8'h11, 8'h22, 15'h0001, 1'b0, 1'b1, 8'h81, 8'hFF, 1'b1};
    run_txn(vt, lc);
    check("timeout_wait_cycles", lc, 255);

    // Reset in WAIT aborts at once without ack.
    req_rnw = 1'b0; req_rom = 1'b0; req_addr = 17'h00002; req_upper = 1'b1; req_wdata = 8'h33;
    req = 1'b1;
    for (int n = 0; n < 20 && VRAMCS; n++) tick();
    repeat (5) tick();
    check("in_wait_before_reset", {VRAMCS, PDS}, 2'b01);
    nRES = 1'b0;
    req = 1'b0;
    #1;
    check("reset_mid_bus", {VRAMCS, PDS, NREAD, nUDS}, 4'b1011);
    check("reset_mid_status", {ack, busy, DB_IN}, 10'd0);
    tick();
    nRES = 1'b1;
    resp_en = 1'b1;
    acks = 0;
    repeat (4) begin
      tick();
      if (ack) acks++;
    end
    check("no_ack_after_reset", acks, 0);
    vt = vecs[1];
    vt.e_dbin = 8'h00;
    run_txn(vt, lc);

    // Back-to-back with req held high.
    req_rnw = 1'b0; req_rom = 1'b0; req_addr = 17'h00010; req_upper = 1'b0; req_wdata = 8'h77;
    req = 1'b1;
    acks = 0; run = 0; min_run = 999; prev_vcs = 1'b1; seen_low = 1'b0;
    for (int n = 0; n < 400 && acks < 2; n++) begin
      tick();
      if (ack) acks++;
      if (VRAMCS) run++;
      else begin
        if (prev_vcs && seen_low && run < min_run) min_run = run;
        seen_low = 1'b1;
        run = 0;
      end
      prev_vcs = VRAMCS;
    end
    req = 1'b0;
    check("b2b_ack_count", acks, 2);
    check("b2b_cs_high_gap", {31'd0, (min_run >= 2 && min_run < 999)}, 32'd1);
    check("b2b_dbin", DB_IN, 8'h77);
    repeat (3) tick();
    check("b2b_idle", {busy, ack, VRAMCS}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
